// File: rtl/puf_response_ctrl.sv
// -----------------------------------------------------------------------------
// puf_response_ctrl
//
// Measurement sequencer and response assembler for a paired ring-oscillator
// PUF. For each response bit it clears both bank counters, enables the
// oscillators for a fixed window, lets the counts settle, then compares
// bank A against bank B. NBITS such bits are packed into one response word
// and handed off with a valid/ack handshake.
//
// Parameters
//   CNT_W          width of each bank count input
//   NBITS          response bits per request (1..32)
//   WINDOW_CYCLES  clk cycles osc_en is high per bit (>=1)
//   SETTLE_CYCLES  clk cycles after osc_en falls before counts are sampled (>=1)
//
// Ports
//   clk         in   1      system clock
//   rst_n       in   1      asynchronous active-low reset
//   start       in   1      request a response (only honoured in IDLE)
//   chal_base   in   5      first challenge, latched on an accepted start
//   cnt_a       in   CNT_W  count from bank A
//   cnt_b       in   CNT_W  count from bank B
//   osc_en      out  1      oscillator enable to both banks
//   cnt_clr     out  1      counter clear to both banks, active high
//   chal        out  5      current challenge select to both banks
//   busy        out  1      high in every state except IDLE
//   resp        out  NBITS  response word; bit i = result for chal_base+i
//   resp_valid  out  1      response available
//   resp_ack    in   1      consumer accepts the response
//   tie         out  1      sticky: some bit of this response saw cnt_a == cnt_b
// -----------------------------------------------------------------------------
module puf_response_ctrl #(
    parameter int CNT_W         = 8,
    parameter int NBITS         = 8,
    parameter int WINDOW_CYCLES = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       chal_base,
    input  logic [CNT_W-1:0] cnt_a,
    input  logic [CNT_W-1:0] cnt_b,
    output logic             osc_en,
    output logic             cnt_clr,
    output logic [4:0]       chal,
    output logic             busy,
    output logic [NBITS-1:0] resp,
    output logic             resp_valid,
    input  logic             resp_ack,
    output logic             tie
);

    // The phase timer must hold the longest phase length without wrapping.
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 2);
    localparam int BIDX_W  = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [TMR_W-1:0]  CLR_LAST  = TMR_W'(1);
    localparam logic [TMR_W-1:0]  RUN_LAST  = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0]  SET_LAST  = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [TMR_W-1:0]   r_timer;
    logic [BIDX_W-1:0]  r_bit_idx;
    logic [4:0]         r_chal;
    logic [NBITS-1:0]   r_resp;
    logic               r_tie;
    logic               r_osc_en;
    logic               r_cnt_clr;
    logic               r_resp_valid;

    logic               w_tmr_done;
    logic               w_last_bit;
    logic               w_start_acc;
    logic               w_ack_acc;
    logic               w_a_gt_b;
    logic               w_a_eq_b;

    assign w_last_bit  = (r_bit_idx == BIDX_LAST);
    assign w_start_acc = (r_state == S_IDLE) && start;
    // Ack is only taken once resp_valid is actually visible to the consumer.
    assign w_ack_acc   = (r_state == S_DONE) && r_resp_valid && resp_ack;
    assign w_a_gt_b    = (cnt_a > cnt_b);
    assign w_a_eq_b    = (cnt_a == cnt_b);

    // ------------------------------------------------------------------
    // Phase timer end detection
    // ------------------------------------------------------------------
    always_comb begin
        w_tmr_done = 1'b0;
        case (r_state)
            S_CLEAR:  w_tmr_done = (r_timer == CLR_LAST);
            S_RUN:    w_tmr_done = (r_timer == RUN_LAST);
            S_SETTLE: w_tmr_done = (r_timer == SET_LAST);
            default:  w_tmr_done = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_acc) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (w_tmr_done) begin
                    w_state_nxt = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_state_nxt = w_last_bit ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                if (w_ack_acc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Phase timer: restarts from zero on every state change
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if ((r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_SETTLE)) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registered bank controls and handshake.
    // Every registered output follows the state with one cycle of lag, so
    // the phase lengths are preserved and the counts have been frozen for
    // exactly SETTLE_CYCLES cycles when COMPARE samples them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_osc_en     <= 1'b0;
            r_cnt_clr    <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_osc_en     <= (r_state == S_RUN);
            r_cnt_clr    <= (r_state == S_CLEAR);
            r_resp_valid <= (r_state == S_DONE) && !w_ack_acc;
        end
    end

    // ------------------------------------------------------------------
    // Challenge stepping and response assembly
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chal    <= '0;
            r_bit_idx <= '0;
            r_resp    <= '0;
            r_tie     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_acc) begin
                        r_chal    <= chal_base;
                        r_bit_idx <= '0;
                        r_resp    <= '0;
                        r_tie     <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    r_resp[r_bit_idx] <= w_a_gt_b;
                    if (w_a_eq_b) begin
                        r_tie <= 1'b1;
                    end
                    if (!w_last_bit) begin
                        // 5-bit add wraps challenge 31 back to 0
                        r_chal    <= r_chal + 5'd1;
                        r_bit_idx <= r_bit_idx + BIDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign osc_en     = r_osc_en;
    assign cnt_clr    = r_cnt_clr;
    assign chal       = r_chal;
    assign busy       = (r_state != S_IDLE);
    assign resp       = r_resp;
    assign resp_valid = r_resp_valid;
    assign tie        = r_tie;

endmodule

// File: tb/tb_puf_response_ctrl.sv
module tb_puf_response_ctrl;

    localparam int CNT_W   = 8;
    localparam int NBITS   = 4;
    localparam int W       = 8;
    localparam int S       = 2;
    localparam int LAT     = NBITS * (W + S + 3) + 1;
    localparam int LAT_MAX = 200;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [4:0]       chal_base;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             osc_en;
    logic             cnt_clr;
    logic [4:0]       chal;
    logic             busy;
    logic [NBITS-1:0] resp;
    logic             resp_valid;
    logic             resp_ack;
    logic             tie;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]      base;
        logic [3:0][4:0] ra;
        logic [3:0][4:0] rb;
        logic [3:0]      resp;
        logic            tie;
    } vec_t;

    typedef struct packed {
        logic [4:0] base;
        logic [3:0] resp;
        logic       tie;
    } exp_t;

    vec_t       vecs [6];
    exp_t       sb_q [$];
    logic [4:0] rate_a [32];
    logic [4:0] rate_b [32];

    puf_response_ctrl #(
        .CNT_W         (CNT_W),
        .NBITS         (NBITS),
        .WINDOW_CYCLES (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .chal_base  (chal_base),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .osc_en     (osc_en),
        .cnt_clr    (cnt_clr),
        .chal       (chal),
        .busy       (busy),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ack   (resp_ack),
        .tie        (tie)
    );

    initial forever #5 clk = ~clk;

    // Bank model: each bank counts at a per-challenge rate while enabled.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (cnt_clr) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (osc_en) begin
            cnt_a <= cnt_a + CNT_W'(rate_a[chal]);
            cnt_b <= cnt_b + CNT_W'(rate_b[chal]);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [4:0] b,
                           input logic [4:0] a0, input logic [4:0] b0,
                           input logic [4:0] a1, input logic [4:0] b1,
                           input logic [4:0] a2, input logic [4:0] b2,
                           input logic [4:0] a3, input logic [4:0] b3,
                           input logic [3:0] r, input logic t);
        vecs[i].base  = b;
        vecs[i].ra[0] = a0; vecs[i].rb[0] = b0;
        vecs[i].ra[1] = a1; vecs[i].rb[1] = b1;
        vecs[i].ra[2] = a2; vecs[i].rb[2] = b2;
        vecs[i].ra[3] = a3; vecs[i].rb[3] = b3;
        vecs[i].resp  = r;
        vecs[i].tie   = t;
    endtask

    task automatic load_rates(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            logic [4:0] c;
            c = v.base + 5'(i);
            rate_a[c] = v.ra[i];
            rate_b[c] = v.rb[i];
        end
    endtask

    task automatic issue_start(input vec_t v);
        exp_t e;
        e.base = v.base;
        e.resp = v.resp;
        e.tie  = v.tie;
        chal_base = v.base;
        start     = 1'b1;
        sb_q.push_back(e);
    endtask

    // Called at #1 after an edge with the DUT in IDLE and start high.
    task automatic run_to_valid(input bit keep_start, output exp_t e);
        int   k;
        int   ol;
        int   cl;
        int   win;
        logic po;
        logic pc;
        bit   seen;
        exp_t h;
        h = (sb_q.size() > 0) ? sb_q[0] : '0;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        chk("accept_busy", int'(busy), 1);
        chk("accept_chal", int'(chal), int'(h.base));
        po = 1'b0; pc = 1'b0; ol = 0; cl = 0; win = 0; seen = 1'b0;
        for (k = 1; k <= LAT_MAX; k++) begin
            @(posedge clk); #1;
            if (cnt_clr) cl++;
            else if (pc) begin
                chk("clr_pulse_len", cl, 2);
                cl = 0;
            end
            if (osc_en && !po) begin
                chk("chal_step", int'(chal), (int'(h.base) + win) % 32);
                win++;
            end
            if (osc_en) ol++;
            else if (po) begin
                chk("window_len", ol, W);
                ol = 0;
            end
            po = osc_en;
            pc = cnt_clr;
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("valid_seen", int'(seen), 1);
        chk("windows", win, NBITS);
        if (sb_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
            if (seen) begin
                chk("latency", k, LAT);
                chk("resp", int'(resp), int'(e.resp));
                chk("tie", int'(tie), int'(e.tie));
                chk("valid_busy", int'(busy), 1);
            end
        end
    endtask

    task automatic do_ack(input exp_t e);
        resp_ack = 1'b1;
        @(posedge clk); #1;
        resp_ack = 1'b0;
        chk("ack_valid_drop", int'(resp_valid), 0);
        chk("ack_idle", int'(busy), 0);
        chk("resp_held", int'(resp), int'(e.resp));
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0; start = 1'b0; resp_ack = 1'b0; chal_base = '0;
        for (int i = 0; i < 32; i++) begin
            rate_a[i] = '0;
            rate_b[i] = '0;
        end
        set_vec(0,  5, 20,10, 10,20, 15, 3,  4, 9, 4'b0101, 1'b0);
        set_vec(1, 30,  2, 3,  3, 2,  6, 1,  1, 6, 4'b0110, 1'b0);
        set_vec(2, 12,  5, 1,  4, 4,  9, 2,  3, 0, 4'b1101, 1'b1);
        set_vec(3,  0,  1, 2,  0, 5,  3, 4,  2,31, 4'b0000, 1'b0);
        set_vec(4, 20, 31,30,  1, 0,  8, 7,  2, 1, 4'b1111, 1'b0);
        set_vec(5, 27,  4, 4,  0, 0, 31,31,  7, 7, 4'b0000, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_osc_en", int'(osc_en), 0);
        chk("rst_cnt_clr", int'(cnt_clr), 0);
        chk("rst_chal", int'(chal), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp", int'(resp), 0);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_tie", int'(tie), 0);
        rst_n = 1'b1;

        // Table-driven responses
        for (int v = 0; v < 6; v++) begin
            load_rates(vecs[v]);
            issue_start(vecs[v]);
            run_to_valid(1'b0, e);
            if (v == 2) begin
                // Stall in DONE with start pulsing; nothing may move.
                for (int c = 0; c < 20; c++) begin
                    start = c[0];
                    @(posedge clk); #1;
                    chk("hold_valid", int'(resp_valid), 1);
                    chk("hold_resp_tie", int'({tie, resp}), int'({e.tie, e.resp}));
                end
                start = 1'b1;
                resp_ack = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                resp_ack = 1'b0;
                chk("ackstart_valid", int'(resp_valid), 0);
                chk("ackstart_idle", int'(busy), 0);
                @(posedge clk); #1;
                chk("ackstart_ignored", int'(busy), 0);
                chk("ackstart_resp_held", int'(resp), int'(e.resp));
            end else begin
                do_ack(e);
            end
        end

        // Reset during the third window, after a tie has been recorded
        load_rates(vecs[2]);
        issue_start(vecs[2]);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (31) @(posedge clk);
        #3;
        chk("pre_rst_osc_en", int'(osc_en), 1);
        chk("pre_rst_tie", int'(tie), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_osc_en", int'(osc_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_resp_valid", int'(resp_valid), 0);
        chk("arst_tie", int'(tie), 0);
        chk("arst_chal", int'(chal), 0);
        chk("arst_resp", int'(resp), 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        load_rates(vecs[0]);
        issue_start(vecs[0]);
        run_to_valid(1'b0, e);
        do_ack(e);

        // Back-to-back with start and ack held high
        load_rates(vecs[4]);
        issue_start(vecs[4]);
        sb_q.push_back(sb_q[0]);
        resp_ack = 1'b1;
        run_to_valid(1'b1, e);
        @(posedge clk); #1;
        chk("b2b_valid_drop", int'(resp_valid), 0);
        chk("b2b_idle_gap", int'(busy), 0);
        run_to_valid(1'b1, e);
        start = 1'b0;
        @(posedge clk); #1;
        resp_ack = 1'b0;
        chk("b2b_end_valid", int'(resp_valid), 0);
        chk("b2b_end_resp", int'(resp), int'(e.resp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
